// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. A snapshot of value/blank/dp is taken at the start of every frame.
//   Each digit slot begins with one all-dark guard cycle and lasts
//   TICKS_PER_DIGIT en_tick strobes.
//
// Parameters
//   TICKS_PER_DIGIT  en_tick strobes per digit slot (1..65535)
//
// Ports
//   in_clk       system clock, rising edge
//   rst          asynchronous reset, active-high
//   en_tick      one-cycle scan-rate strobe
//   value_in     four hex digits, [3:0] = digit 0 (rightmost)
//   blank_in     per-digit force-blank mask, 1 = blank
//   dp_in        per-digit decimal point, 1 = lit
//   anode        digit enables, active-low (one-hot-low or all-high)
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame_start  one-cycle pulse when a new snapshot is taken
//
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN  defined: digits 3..1 are blanked while they
//   and every higher digit of the snapshot are zero. Digit 0 always shows.

module seg7_scan_ctrl #(
  parameter int unsigned TICKS_PER_DIGIT = 4
) (
  input  logic        in_clk,
  input  logic        rst,
  input  logic        en_tick,
  input  logic [15:0] value_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    WAIT_TICK = 2'd0,
    GUARD     = 2'd1,
    SHOW      = 2'd2
  } state_t;

  localparam logic [16:0] TICKS = 17'(TICKS_PER_DIGIT);

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [15:0] dwell, dwell_nx;
  logic [16:0] dwell_inc;
  logic [15:0] sh_val, sh_val_nx;
  logic [3:0]  sh_blank, sh_blank_nx;
  logic [3:0]  sh_dp, sh_dp_nx;
  logic        load;

  logic [3:0]  nib;
  logic        lz_blank;
  logic        lit;
  logic [3:0]  anode_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_TICK;
      idx         <= '0;
      dwell       <= '0;
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_dp       <= '0;
      anode       <= '1;
      seg         <= '1;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      dwell       <= dwell_nx;
      sh_val      <= sh_val_nx;
      sh_blank    <= sh_blank_nx;
      sh_dp       <= sh_dp_nx;
      anode       <= anode_nx;
      seg         <= seg_nx;
      dp          <= dp_nx;
      frame_start <= load;
    end
  end

  // Ticks seen in GUARD also count, and the slot ends on the first SHOW tick
  // at or past the limit, so a continuously high en_tick with a limit of 1
  // still advances on every SHOW cycle.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    dwell_nx  = dwell;
    load      = 1'b0;
    dwell_inc = {1'b0, dwell} + 17'd1;
    case (state)
      WAIT_TICK: begin
        if (en_tick) begin
          load     = 1'b1;
          idx_nx   = '0;
          dwell_nx = '0;
          state_nx = GUARD;
        end
      end
      GUARD: begin
        state_nx = SHOW;
        if (en_tick) dwell_nx = dwell_inc[15:0];
      end
      SHOW: begin
        if (en_tick) begin
          if (dwell_inc >= TICKS) begin
            state_nx = GUARD;
            dwell_nx = '0;
            idx_nx   = idx + 2'd1;
            load     = (idx == 2'd3);
          end else begin
            dwell_nx = dwell_inc[15:0];
          end
        end
      end
      default: begin
        state_nx = WAIT_TICK;
        idx_nx   = '0;
        dwell_nx = '0;
      end
    endcase
  end

  always_comb begin
    sh_val_nx   = load ? value_in : sh_val;
    sh_blank_nx = load ? blank_in : sh_blank;
    sh_dp_nx    = load ? dp_in    : sh_dp;
  end

  // Outputs are decoded from the next-state values and registered, so they
  // line up with the state register cycle-for-cycle without any input path.
  always_comb begin
    nib = sh_val_nx[{idx_nx, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz_blank = (idx_nx != 2'd0) && ((sh_val_nx >> {idx_nx, 2'b00}) == 16'd0);
`else
    lz_blank = 1'b0;
`endif
    lit      = (state_nx == SHOW) && !sh_blank_nx[idx_nx] && !lz_blank;
    anode_nx = '1;
    seg_nx   = '1;
    dp_nx    = 1'b1;
    if (lit) begin
      anode_nx = ~(4'b0001 << idx_nx);
      seg_nx   = hex_decode(nib);
      dp_nx    = ~sh_dp_nx[idx_nx];
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter TICKS_PER_DIGIT, default 4, meaning: number of en_tick strobes each digit is shown; legal range 1..65535.
REQ-002 in_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en_tick  input  1  one-in_clk-cycle strobe from the upstream clock divider stage; sets the scan rate.
REQ-005 value_in  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 blank_in  input  4  per-digit force-blank mask, 1 = blank.
REQ-007 dp_in  input  4  per-digit decimal point, 1 = lit.
REQ-008 anode  output  4  digit enables, active-low, one-hot-low or all-high.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 frame_start  output  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-012 The FSM shall have three states: WAIT_TICK, GUARD and SHOW.
REQ-013 In WAIT_TICK, en_tick=1 shall load the shadow registers (value_in, blank_in, dp_in), set digit index to 0, pulse frame_start and enter GUARD.
REQ-014 GUARD shall last exactly one in_clk cycle with anode=1111, then enter SHOW.
REQ-015 In SHOW, anode shall drive only bit [index] low, seg shall drive the hex decode of the shadow nibble and dp shall drive ~shadow_dp[index].
REQ-016 Hex decode shall be the standard active-low table, e.g. 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110.
REQ-017 The dwell counter shall clear when GUARD is entered and increment on each en_tick in GUARD or SHOW.
REQ-018 When SHOW sees en_tick with dwell = TICKS_PER_DIGIT-1, the index shall advance 0->1->2->3->0 and the FSM shall enter GUARD.
REQ-019 On the 3->0 wrap, the shadow registers shall reload from the inputs and frame_start shall pulse in that same cycle.
REQ-020 Inputs changing mid-frame shall not affect the display until the next snapshot.
REQ-021 A digit with shadow blank bit = 1 shall keep anode all-high for its whole slot while still consuming its dwell time.
REQ-022 With TICKS_PER_DIGIT=1, each digit slot shall last from one en_tick to the next.
REQ-023 en_tick held high continuously shall count on every cycle with no lost or doubled advance.
REQ-024 anode, seg, dp and frame_start shall be registered outputs with no combinational path from the inputs.

Reset
REQ-025 While rst=1: state=WAIT_TICK, index=0, dwell=0, shadow registers=0, anode=1111, seg=1111111, dp=1, frame_start=0.
REQ-026 Asserting rst mid-scan shall force the REQ-025 values immediately, without waiting for an in_clk edge.
REQ-027 After rst deasserts, the first en_tick shall start a frame per REQ-013.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digits 3..1 whose shadow nibble is 0 and whose higher digits are all 0 shall be blanked as in REQ-021; digit 0 is never auto-blanked; a digit's dp does not prevent blanking.
REQ-029 Macro SEG7_LEADING_ZERO_BLANK_EN undefined: blanking shall come only from blank_in, and zero digits shall display as 0.

Verification
REQ-030 Reset, then value_in=16'h12AF with TICKS_PER_DIGIT=2 and en_tick every 4th cycle -> frame_start pulse; anode sequence 1110/1101/1011/0111 with seg 0001110, 0001000, 0100100, 1111001; each slot 2 ticks; one all-high guard cycle between slots.
REQ-031 value_in changes 16'h1111->16'h2222 during digit 1 -> digits 2 and 3 still show 1; next frame shows 2 on all digits.
REQ-032 blank_in=4'b0100, dp_in=4'b0001 -> slot 2 has anode=1111 for its full duration; dp=0 only during the digit 0 slot.
REQ-033 Macro defined, value_in=16'h0070 -> digits 3 and 2 blank, digit 1 seg=1111000, digit 0 seg=1000000; macro undefined -> digits 3 and 2 show 1000000.
REQ-034 rst pulsed during the digit 2 slot -> outputs reach reset values with no in_clk edge; the first tick after release restarts at digit 0 with a new snapshot.
REQ-035 TICKS_PER_DIGIT=1 with en_tick held high -> index advances every 2 cycles (SHOW, GUARD) and frame_start fires every 8 cycles.
